// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the supervisor/machine trap controller: CSR indices,
// the system-instruction encodings decoded at writeback, exception cause codes
// and the trap sequencing FSM state type.
// -----------------------------------------------------------------------------
package trap_pkg;

    // CSR indices held by the trap CSR file
    localparam logic [11:0] CSR_STVEC  = 12'h105;
    localparam logic [11:0] CSR_SEPC   = 12'h141;
    localparam logic [11:0] CSR_SCAUSE = 12'h142;
    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;

    // Full instruction words recognised at writeback
    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_UNIMP = 32'hc000_1073;
    localparam logic [31:0] INST_SRET  = 32'h1020_0073;
    localparam logic [31:0] INST_MRET  = 32'h3020_0073;

    // Exception cause codes written to scause
    localparam logic [3:0] CAUSE_ILLEGAL_INST = 4'd2;
    localparam logic [3:0] CAUSE_ECALL        = 4'd8;

    // Trap sequencing: one flush cycle, then hold the redirect until accepted
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT
    } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// -----------------------------------------------------------------------------
// trap_csr_file
// Storage for stvec/sepc/scause/mtvec/mepc/mcause with a combinational read
// port and a dedicated trap-capture write port.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   csr_we_i          software CSR write strobe
//   csr_addr_i        CSR index for both read and write
//   csr_wdata_i       software CSR write data
//   csr_rdata_o       combinational read of csr_addr_i (0 for unknown index)
//   trap_we_i         trap capture strobe (updates sepc and scause)
//   trap_epc_i        value captured into sepc
//   trap_cause_i      value captured into scause
//   stvec_o/sepc_o/mepc_o  low PC_W bits of the redirect source CSRs
// -----------------------------------------------------------------------------
module trap_csr_file
    import trap_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    input  logic            trap_we_i,
    input  logic [XLEN-1:0] trap_epc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    output logic [PC_W-1:0] stvec_o,
    output logic [PC_W-1:0] sepc_o,
    output logic [PC_W-1:0] mepc_o
);

    logic [XLEN-1:0] stvec_q;
    logic [XLEN-1:0] sepc_q;
    logic [XLEN-1:0] scause_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;

    // Software writes first, trap capture afterwards: when both hit sepc or
    // scause in the same cycle the later non-blocking assignment (the trap)
    // wins, while a software write to any other CSR still lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stvec_q  <= '0;
            sepc_q   <= '0;
            scause_q <= '0;
            mtvec_q  <= '0;
            mepc_q   <= '0;
            mcause_q <= '0;
        end else begin
            if (csr_we_i) begin
                case (csr_addr_i)
                    CSR_STVEC:  stvec_q  <= csr_wdata_i;
                    CSR_SEPC:   sepc_q   <= csr_wdata_i;
                    CSR_SCAUSE: scause_q <= csr_wdata_i;
                    CSR_MTVEC:  mtvec_q  <= csr_wdata_i;
                    CSR_MEPC:   mepc_q   <= csr_wdata_i;
                    CSR_MCAUSE: mcause_q <= csr_wdata_i;
                    default:    ;
                endcase
            end
            if (trap_we_i) begin
                sepc_q   <= trap_epc_i;
                scause_q <= trap_cause_i;
            end
        end
    end

    // Read mux: unknown indices read as zero
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_STVEC:  csr_rdata_o = stvec_q;
            CSR_SEPC:   csr_rdata_o = sepc_q;
            CSR_SCAUSE: csr_rdata_o = scause_q;
            CSR_MTVEC:  csr_rdata_o = mtvec_q;
            CSR_MEPC:   csr_rdata_o = mepc_q;
            CSR_MCAUSE: csr_rdata_o = mcause_q;
            default:    csr_rdata_o = '0;
        endcase
    end

    assign stvec_o = stvec_q[PC_W-1:0];
    assign sepc_o  = sepc_q[PC_W-1:0];
    assign mepc_o  = mepc_q[PC_W-1:0];

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Decodes ecall/unimp/sret/mret at writeback, captures trap state into the
// CSR file, then flushes the pipeline for one cycle and offers a redirect
// that is held until the PC register accepts it.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   wb_valid, wb_inst, wb_pc        retiring instruction
//   csr_we, csr_addr, csr_wdata     software CSR write port
//   csr_rdata                       combinational CSR read of csr_addr
//   flush                           kill younger stages (one cycle)
//   stall                           freeze fetch/retire while sequencing
//   redirect_valid/ready/pc         redirect handshake to the PC register
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [31:0]     wb_inst,
    input  logic [PC_W-1:0] wb_pc,
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            flush,
    output logic            stall,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [PC_W-1:0] redirect_pc
);

    trap_state_e     state_q;
    logic [PC_W-1:0] target_q;
    logic [PC_W-1:0] target_d;
    logic            flush_q;
    logic            stall_q;
    logic            redirectValid_q;
    logic [PC_W-1:0] redirectPc_q;

    logic [PC_W-1:0] stvecPc;
    logic [PC_W-1:0] sepcPc;
    logic [PC_W-1:0] mepcPc;

    logic            eventValid;
    logic            isEcall;
    logic            isUnimp;
    logic            isSret;
    logic            isMret;
    logic            trapTake;
    logic            returnTake;
    logic [XLEN-1:0] trapCause;

    // Retirement events are only honoured while idle; anything arriving
    // during a flush or redirect is dropped.
    assign eventValid = wb_valid && (state_q == ST_IDLE);
    assign isEcall    = eventValid && (wb_inst == INST_ECALL);
    assign isUnimp    = eventValid && (wb_inst == INST_UNIMP);
    assign isSret     = eventValid && (wb_inst == INST_SRET);
    assign isMret     = eventValid && (wb_inst == INST_MRET);
    assign trapTake   = isEcall || isUnimp;
    assign returnTake = isSret || isMret;
    assign trapCause  = isEcall ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_ILLEGAL_INST);

    trap_csr_file #(
        .XLEN (XLEN),
        .PC_W (PC_W)
    ) u_csr_file (
        .clk          (clk),
        .rst          (rst),
        .csr_we_i     (csr_we),
        .csr_addr_i   (csr_addr),
        .csr_wdata_i  (csr_wdata),
        .csr_rdata_o  (csr_rdata),
        .trap_we_i    (trapTake),
        .trap_epc_i   (XLEN'(wb_pc)),
        .trap_cause_i (trapCause),
        .stvec_o      (stvecPc),
        .sepc_o       (sepcPc),
        .mepc_o       (mepcPc)
    );

    // Redirect target chosen from pre-edge CSR values; trap vectors are
    // forced to direct mode by clearing the two mode bits.
    always_comb begin
        target_d = target_q;
        if (trapTake) begin
            target_d = {stvecPc[PC_W-1:2], 2'b00};
        end else if (isSret) begin
            target_d = sepcPc;
        end else if (isMret) begin
            target_d = mepcPc;
        end
    end

    // Sequencer with registered outputs: flush is high for the single FLUSH
    // cycle, the redirect is presented from the following cycle and held
    // until accepted. Reset aborts the sequence at any point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            target_q        <= '0;
            flush_q         <= 1'b0;
            stall_q         <= 1'b0;
            redirectValid_q <= 1'b0;
            redirectPc_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trapTake || returnTake) begin
                        state_q  <= ST_FLUSH;
                        target_q <= target_d;
                        flush_q  <= 1'b1;
                        stall_q  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state_q         <= ST_REDIRECT;
                    flush_q         <= 1'b0;
                    redirectValid_q <= 1'b1;
                    redirectPc_q    <= target_q;
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_q         <= ST_IDLE;
                        stall_q         <= 1'b0;
                        redirectValid_q <= 1'b0;
                        redirectPc_q    <= '0;
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    flush_q         <= 1'b0;
                    stall_q         <= 1'b0;
                    redirectValid_q <= 1'b0;
                    redirectPc_q    <= '0;
                end
            endcase
        end
    end

    assign flush          = flush_q;
    assign stall          = stall_q;
    assign redirect_valid = redirectValid_q;
    assign redirect_pc    = redirectPc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Directed scoreboard bench for trap_ctrl: expected values are queued as each
// step is driven and popped when the corresponding DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam int XLEN = 64;
    localparam int PC_W = 32;

    logic            clk;
    logic            rst;
    logic            wb_valid;
    logic [31:0]     wb_inst;
    logic [PC_W-1:0] wb_pc;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            flush;
    logic            stall;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [PC_W-1:0] redirect_pc;

    typedef struct {
        string       tag;
        logic [63:0] value;
    } exp_t;

    exp_t sbQ[$];
    int   nCompared;
    int   nMismatched;

    trap_ctrl #(
        .XLEN (XLEN),
        .PC_W (PC_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wb_valid       (wb_valid),
        .wb_inst        (wb_inst),
        .wb_pc          (wb_pc),
        .csr_we         (csr_we),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .flush          (flush),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectValue(input string tag, input logic [63:0] value);
        sbQ.push_back('{tag, value});
    endtask

    // Pop the oldest expectation and compare it against the sampled value
    task automatic checkOutput(input logic [63:0] observed);
        exp_t e;
        nCompared++;
        if (sbQ.size() == 0) begin
            nMismatched++;
            $error("[TB] FAIL scoreboard_empty observed=0x%0h expected=none", observed);
        end else begin
            e = sbQ.pop_front();
            assert (observed === e.value)
            else begin
                nMismatched++;
                $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", e.tag, observed, e.value);
            end
        end
    endtask

    // Retire one instruction, optionally with a simultaneous CSR write
    task automatic applyStimulus(input logic [31:0] inst, input logic [PC_W-1:0] pc,
                                 input logic we, input logic [11:0] addr,
                                 input logic [XLEN-1:0] data);
        wb_valid  = 1'b1;
        wb_inst   = inst;
        wb_pc     = pc;
        csr_we    = we;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        wb_valid  = 1'b0;
        wb_inst   = 32'h0;
        csr_we    = 1'b0;
    endtask

    task automatic csrWrite(input logic [11:0] addr, input logic [XLEN-1:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic csrCheck(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        csr_addr = addr;
        #1;
        expectValue(tag, exp);
        checkOutput(csr_rdata);
    endtask

    task automatic outCheck(input string tag, input logic expFlush, input logic expStall,
                            input logic expValid, input logic [PC_W-1:0] expPc);
        expectValue({tag, "_flush"}, 64'(expFlush));
        checkOutput(64'(flush));
        expectValue({tag, "_stall"}, 64'(expStall));
        checkOutput(64'(stall));
        expectValue({tag, "_rvalid"}, 64'(expValid));
        checkOutput(64'(redirect_valid));
        expectValue({tag, "_rpc"}, 64'(expPc));
        checkOutput(64'(redirect_pc));
    endtask

    // After the event edge: flush cycle, redirect cycle (ready high), idle
    task automatic trapSeq(input string tag, input logic [PC_W-1:0] expTarget);
        outCheck({tag, "_n1"}, 1'b1, 1'b1, 1'b0, '0);
        tick();
        outCheck({tag, "_n2"}, 1'b0, 1'b1, 1'b1, expTarget);
        tick();
        outCheck({tag, "_idle"}, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        nCompared      = 0;
        nMismatched    = 0;
        rst            = 1'b1;
        wb_valid       = 1'b0;
        wb_inst        = 32'h0;
        wb_pc          = '0;
        csr_we         = 1'b0;
        csr_addr       = 12'h0;
        csr_wdata      = '0;
        redirect_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset state");
        outCheck("rst", 1'b0, 1'b0, 1'b0, '0);
        csrCheck("rst_stvec", CSR_STVEC, 64'h0);
        csrCheck("rst_sepc", CSR_SEPC, 64'h0);
        csrCheck("rst_scause", CSR_SCAUSE, 64'h0);
        csrCheck("rst_mtvec", CSR_MTVEC, 64'h0);
        csrCheck("rst_mepc", CSR_MEPC, 64'h0);
        csrCheck("rst_mcause", CSR_MCAUSE, 64'h0);

        $display("[TB] unknown CSR write discarded");
        csrWrite(12'h7c0, 64'hdead);
        csrCheck("unk_read", 12'h7c0, 64'h0);

        $display("[TB] ecall with stvec mode bits set");
        csrWrite(CSR_STVEC, 64'h8001);
        csrCheck("stvec_wr", CSR_STVEC, 64'h8001);
        applyStimulus(INST_ECALL, 32'h1000, 1'b0, CSR_STVEC, '0);
        trapSeq("ecall", 32'h8000);
        csrCheck("ecall_sepc", CSR_SEPC, 64'h1000);
        csrCheck("ecall_scause", CSR_SCAUSE, 64'd8);

        $display("[TB] unimp with redirect held off");
        redirect_ready = 1'b0;
        applyStimulus(INST_UNIMP, 32'h2004, 1'b0, CSR_STVEC, '0);
        outCheck("unimp_n1", 1'b1, 1'b1, 1'b0, '0);
        tick();
        for (int i = 0; i < 3; i++) begin
            outCheck("unimp_hold", 1'b0, 1'b1, 1'b1, 32'h8000);
            tick();
        end
        outCheck("unimp_last", 1'b0, 1'b1, 1'b1, 32'h8000);
        redirect_ready = 1'b1;
        tick();
        outCheck("unimp_idle", 1'b0, 1'b0, 1'b0, '0);
        csrCheck("unimp_scause", CSR_SCAUSE, 64'd2);
        csrCheck("unimp_sepc", CSR_SEPC, 64'h2004);

        $display("[TB] mret and sret");
        csrWrite(CSR_MEPC, 64'h3000);
        csrWrite(CSR_MCAUSE, 64'hb);
        applyStimulus(INST_MRET, 32'h0abc, 1'b0, CSR_MEPC, '0);
        trapSeq("mret", 32'h3000);
        csrCheck("mret_mepc", CSR_MEPC, 64'h3000);
        csrCheck("mret_mcause", CSR_MCAUSE, 64'hb);
        csrCheck("mret_sepc", CSR_SEPC, 64'h2004);
        applyStimulus(INST_SRET, 32'h0def, 1'b0, CSR_SEPC, '0);
        trapSeq("sret", 32'h2004);
        csrCheck("sret_scause", CSR_SCAUSE, 64'd2);

        $display("[TB] CSR write colliding with trap capture");
        applyStimulus(INST_ECALL, 32'h0100, 1'b1, CSR_SEPC, 64'h5555);
        trapSeq("coll_sepc", 32'h8000);
        csrCheck("coll_sepc", CSR_SEPC, 64'h100);
        csrCheck("coll_scause", CSR_SCAUSE, 64'd8);
        applyStimulus(INST_UNIMP, 32'h0104, 1'b1, CSR_MTVEC, 64'h1234);
        trapSeq("coll_mtvec", 32'h8000);
        csrCheck("coll_mtvec", CSR_MTVEC, 64'h1234);
        csrCheck("coll_sepc2", CSR_SEPC, 64'h104);
        csrCheck("coll_scause2", CSR_SCAUSE, 64'd2);

        $display("[TB] second ecall during flush");
        applyStimulus(INST_ECALL, 32'h0400, 1'b0, CSR_STVEC, '0);
        outCheck("dbl_n1", 1'b1, 1'b1, 1'b0, '0);
        wb_valid = 1'b1;
        wb_inst  = INST_ECALL;
        wb_pc    = 32'h0600;
        tick();
        wb_valid = 1'b0;
        outCheck("dbl_n2", 1'b0, 1'b1, 1'b1, 32'h8000);
        tick();
        for (int i = 0; i < 3; i++) begin
            outCheck("dbl_idle", 1'b0, 1'b0, 1'b0, '0);
            tick();
        end
        csrCheck("dbl_sepc", CSR_SEPC, 64'h400);

        $display("[TB] reset during redirect");
        redirect_ready = 1'b0;
        applyStimulus(INST_ECALL, 32'h0700, 1'b0, CSR_STVEC, '0);
        tick();
        outCheck("rr_pre", 1'b0, 1'b1, 1'b1, 32'h8000);
        rst = 1'b1;
        #1;
        outCheck("rr_async", 1'b0, 1'b0, 1'b0, '0);
        csrCheck("rr_sepc", CSR_SEPC, 64'h0);
        csrCheck("rr_stvec", CSR_STVEC, 64'h0);
        tick();
        rst = 1'b0;
        redirect_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            outCheck("rr_after", 1'b0, 1'b0, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, the CSR data width.
REQ-002 The block SHALL have parameter PC_W, default 32, the PC width; redirect targets are CSR[PC_W-1:0].
REQ-003 The block SHALL have port clk, input, 1, the clock.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port wb_valid, input, 1, a retiring instruction is present.
REQ-006 The block SHALL have port wb_inst, input, 32, the retiring instruction word.
REQ-007 The block SHALL have port wb_pc, input, PC_W, the retiring instruction address.
REQ-008 The block SHALL have port csr_we, input, 1, the CSR write strobe.
REQ-009 The block SHALL have port csr_addr, input, 12, the CSR index.
REQ-010 The block SHALL have port csr_wdata, input, XLEN, the CSR write data.
REQ-011 The block SHALL have port csr_rdata, output, XLEN, the combinational read of csr_addr (0 for unknown).
REQ-012 The block SHALL have port flush, output, 1, kill all younger pipeline stages.
REQ-013 The block SHALL have port stall, output, 1, freeze fetch/retire while busy.
REQ-014 The block SHALL have port redirect_valid, output, 1, redirect_pc is offered.
REQ-015 The block SHALL have port redirect_ready, input, 1, the PC register accepts the redirect.
REQ-016 The block SHALL have port redirect_pc, output, PC_W, the new fetch address.

Function
REQ-017 The block SHALL hold CSRs stvec 0x105, sepc 0x141, scause 0x142, mtvec 0x305, mepc 0x341, mcause 0x342, each XLEN wide.
REQ-018 The block SHALL decode, only when wb_valid=1 and the FSM is IDLE: ecall=0x00000073, unimp=0xc0001073, sret=0x10200073, mret=0x30200073.
REQ-019 The block SHALL implement FSM states IDLE, FLUSH, REDIRECT.
REQ-020 On ecall or unimp in IDLE the block SHALL write sepc<=wb_pc zero-extended, scause<=8 (ecall) or 2 (unimp), latch target stvec with bits[1:0] forced 0, and go to FLUSH.
REQ-021 On sret or mret in IDLE the block SHALL latch target sepc or mepc respectively, leave CSRs unchanged, and go to FLUSH.
REQ-022 FLUSH SHALL last exactly one cycle with flush=1, then go to REDIRECT.
REQ-023 In REDIRECT redirect_valid SHALL be 1 and redirect_pc SHALL stay stable until redirect_ready=1; on that edge the FSM SHALL return to IDLE.
REQ-024 Latency SHALL be: event sampled at edge N, flush high during cycle N+1, redirect_valid first high in cycle N+2.
REQ-025 stall SHALL be 1 in FLUSH and REDIRECT and 0 in IDLE.
REQ-026 wb_valid events outside IDLE SHALL be ignored with no CSR or state change.
REQ-027 A CSR write in the same cycle as an ecall/unimp capture SHALL lose to the trap update for sepc and scause; writes to other CSRs SHALL proceed.
REQ-028 CSR writes to unknown addresses SHALL be discarded; csr_rdata SHALL reflect pre-edge values.
REQ-029 If redirect_ready=1 in the first REDIRECT cycle, the FSM SHALL return to IDLE after one cycle.

Reset
REQ-030 On rst the block SHALL force state=IDLE; all six CSRs, the latched target, flush, stall, redirect_valid and redirect_pc SHALL be 0.
REQ-031 rst asserted mid-trap SHALL abort the sequence immediately, with no further redirect issued.

Structure
REQ-032 CSR address constants, instruction encodings, cause codes and the FSM state enum SHALL live in the shared package trap_pkg.
REQ-033 The CSR storage with its read mux SHALL be a sub-module trap_csr_file; FSM and decode SHALL stay in trap_ctrl.

Verification
REQ-034 ecall at wb_pc=0x1000, stvec=0x8001 -> sepc=0x1000, scause=8, flush at N+1, redirect_pc=0x8000 at N+2.
REQ-035 unimp at wb_pc=0x2004 with redirect_ready held 0 for 3 cycles -> scause=2, redirect_valid and redirect_pc stable 3 cycles, IDLE one cycle after ready.
REQ-036 csrw mepc=0x3000, then mret -> redirect_pc=0x3000, mepc/mcause unchanged.
REQ-037 csrw sepc=0x5555 in the same cycle as ecall at 0x100 -> sepc=0x100.
REQ-038 Second ecall issued during FLUSH -> ignored, sepc keeps the first value, single redirect.
REQ-039 rst pulsed while in REDIRECT -> all outputs 0 next cycle, state IDLE, no redirect.
